// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the ROB-to-memory responder: size codes, FSM states
// and the default IO window.
package mem_ctrl_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;
    localparam int          IO_SPAN_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Size code 11 is treated as a word access.
    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            MEM_B:   return 3'd1;
            MEM_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load-result extension: takes the assembled little-endian bytes and widens
// them to 32 bits, sign- or zero-extending from bit 8N-1.
module mem_load_ext
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] bytes_i,
    input  logic [2:0]  n_i,
    input  logic        signed_i,
    output logic [31:0] value_o
);

    always_comb begin
        value_o = bytes_i;
        case (n_i)
            3'd1:    value_o = {{24{signed_i & bytes_i[7]}},  bytes_i[7:0]};
            3'd2:    value_o = {{16{signed_i & bytes_i[15]}}, bytes_i[15:0]};
            default: value_o = bytes_i;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Responder end of the ROB-to-memory interface: serialises one load or store
// at a time into byte transfers on a byte-wide RAM/IO bus.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
    parameter int          IO_SPAN = IO_SPAN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              RN,
    input  logic              WN,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       Wvalue,
    input  logic [1:0]        Size,
    input  logic              Signed,
    output logic              Mem_Success,
    output logic [31:0]       Read_Value,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_e            state_q;
    logic [2:0]        cnt_q;
    logic [2:0]        n_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              sgn_q;
    logic [31:0]       buf_q;
    logic [31:0]       rval_q;
    logic              succ_q;
    logic [ADDR_W-1:0] mem_a_q;
    logic [7:0]        dout_q;
    logic              wr_q;
    logic              io_q;

    logic [2:0]        cnt_inc;
    logic [ADDR_W-1:0] next_a;
    logic [31:0]       bytes_d;
    logic [31:0]       ext_value;
    logic              stall;

    function automatic logic in_io(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - ADDR_W'(IO_BASE);
        return off < ADDR_W'(IO_SPAN);
    endfunction

    assign cnt_inc = cnt_q + 3'd1;
    assign next_a  = addr_q + ADDR_W'(cnt_inc);
    assign stall   = io_q & io_buffer_full;

    // Byte k-1 arrives on mem_din during cycle k; fold it in before extension
    // so the final byte can be used at the same edge it is captured.
    always_comb begin
        bytes_d = buf_q;
        case (cnt_q)
            3'd1:    bytes_d[7:0]   = mem_din;
            3'd2:    bytes_d[15:8]  = mem_din;
            3'd3:    bytes_d[23:16] = mem_din;
            3'd4:    bytes_d[31:24] = mem_din;
            default: bytes_d = buf_q;
        endcase
    end

    mem_load_ext u_ext (
        .bytes_i  (bytes_d),
        .n_i      (n_q),
        .signed_i (sgn_q),
        .value_o  (ext_value)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            n_q     <= 3'd1;
            addr_q  <= '0;
            wdata_q <= '0;
            sgn_q   <= 1'b0;
            buf_q   <= '0;
            rval_q  <= '0;
            succ_q  <= 1'b1;
            mem_a_q <= '0;
            dout_q  <= '0;
            wr_q    <= 1'b0;
            io_q    <= 1'b0;
        end else if (rdy) begin
            case (state_q)
                ST_IDLE: begin
                    if (WN) begin
                        state_q <= ST_WRITE;
                        addr_q  <= Addr;
                        wdata_q <= Wvalue;
                        n_q     <= size_to_n(Size);
                        cnt_q   <= 3'd0;
                        mem_a_q <= Addr;
                        dout_q  <= Wvalue[7:0];
                        wr_q    <= 1'b1;
                        io_q    <= in_io(Addr);
                        succ_q  <= 1'b0;
                    end else if (RN && !clr) begin
                        state_q <= ST_READ;
                        addr_q  <= Addr;
                        n_q     <= size_to_n(Size);
                        sgn_q   <= Signed;
                        cnt_q   <= 3'd0;
                        mem_a_q <= Addr;
                        wr_q    <= 1'b0;
                        succ_q  <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (clr) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 3'd0;
                        succ_q  <= 1'b1;
                    end else begin
                        buf_q <= bytes_d;
                        if (cnt_q == n_q) begin
                            rval_q  <= ext_value;
                            state_q <= ST_IDLE;
                            cnt_q   <= 3'd0;
                            succ_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc < n_q) begin
                                mem_a_q <= next_a;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    // A committed store ignores clr; only a full UART buffer stalls it.
                    if (!stall) begin
                        if (cnt_inc == n_q) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= 3'd0;
                            wr_q    <= 1'b0;
                            succ_q  <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_inc;
                            mem_a_q <= next_a;
                            dout_q  <= wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
                            io_q    <= in_io(next_a);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    succ_q  <= 1'b1;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign Mem_Success = succ_q;
    assign Read_Value  = rval_q;
    assign mem_a       = mem_a_q;
    assign mem_dout    = dout_q;
    assign mem_wr      = wr_q & rdy & ~stall;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: behavioural byte RAM on the bus side,
// reference memory image plus load-result model on the checking side.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clr = 1'b0;
    logic        RN = 1'b0;
    logic        WN = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] Wvalue = '0;
    logic [1:0]  Size = '0;
    logic        Signed = 1'b0;
    logic        Mem_Success;
    logic [31:0] Read_Value;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] exp_q[$];

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .clr            (clr),
        .RN             (RN),
        .WN             (WN),
        .Addr           (Addr),
        .Wvalue         (Wvalue),
        .Size           (Size),
        .Signed         (Signed),
        .Mem_Success    (Mem_Success),
        .Read_Value     (Read_Value),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    // ---------------- clock / RAM ----------------
    always #5 clk = ~clk;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    always @(posedge clk) begin
        mem_din <= ram_rd(mem_a);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic int size_n(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s,
                                               input logic sg);
        int n;
        logic [31:0] v;
        n = size_n(s);
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_rd(a + 32'(i))) << (8 * i));
        if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a]     = b;
        ref_mem[a] = b;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] s, input logic sg);
        int n;
        logic [31:0] e;
        n = size_n(s);
        exp_q.push_back(model_load(a, s, sg));
        RN = 1'b1; WN = 1'b0; Addr = a; Size = s; Signed = sg;
        tick();
        RN = 1'b0; Addr = $urandom; Size = 2'($urandom); Signed = 1'($urandom);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            n_checks++;
            if (mem_a !== a + 32'(k)) begin
                n_fail++;
                $display("FAIL load_addr k=%0d: got %h expected %h", k, mem_a, a + 32'(k));
            end
            n_checks++;
            if (Mem_Success !== 1'b0 || mem_wr !== 1'b0) begin
                n_fail++;
                $display("FAIL load_busy k=%0d: success=%b wr=%b expected 0 0", k, Mem_Success, mem_wr);
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (Mem_Success !== 1'b0) begin
            n_fail++;
            $display("FAIL load_last_busy: success=%b expected 0", Mem_Success);
        end
        tick();
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (Mem_Success !== 1'b1) begin
            n_fail++;
            $display("FAIL load_done: success=%b expected 1", Mem_Success);
        end
        n_checks++;
        if (Read_Value !== e) begin
            n_fail++;
            $display("FAIL load_value addr=%h size=%0d sg=%b: got %h expected %h", a, s, sg, Read_Value, e);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] wv,
                            input logic both);
        int n;
        logic [7:0] eb;
        n = size_n(s);
        RN = both; WN = 1'b1; Addr = a; Size = s; Wvalue = wv; Signed = 1'($urandom);
        tick();
        RN = 1'b0; WN = 1'b0; Addr = $urandom; Wvalue = $urandom;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            eb = 8'(wv >> (8 * k));
            n_checks++;
            if (mem_wr !== 1'b1 || mem_a !== a + 32'(k) || mem_dout !== eb) begin
                n_fail++;
                $display("FAIL store_beat k=%0d: wr=%b a=%h d=%h expected 1 %h %h",
                         k, mem_wr, mem_a, mem_dout, a + 32'(k), eb);
            end
            n_checks++;
            if (Mem_Success !== 1'b0) begin
                n_fail++;
                $display("FAIL store_busy k=%0d: success=%b expected 0", k, Mem_Success);
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (Mem_Success !== 1'b1 || mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL store_done: success=%b wr=%b expected 1 0", Mem_Success, mem_wr);
        end
        for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = 8'(wv >> (8 * k));
        for (int k = 0; k <= n; k++) begin
            n_checks++;
            if (ram_rd(a + 32'(k)) !== ref_rd(a + 32'(k))) begin
                n_fail++;
                $display("FAIL store_ram addr=%h: got %h expected %h",
                         a + 32'(k), ram_rd(a + 32'(k)), ref_rd(a + 32'(k)));
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if (Mem_Success !== 1'b1 || mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: success=%b wr=%b expected 1 0", Mem_Success, mem_wr);
        end
        n_checks++;
        if (Read_Value !== 32'h0 || mem_a !== 32'h0 || mem_dout !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_data: rv=%h a=%h d=%h expected 0 0 0", Read_Value, mem_a, mem_dout);
        end
        rst = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (Mem_Success !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_reset: success=%b expected 1", Mem_Success);
        end
    endtask

    task automatic test_load_word();
        preload(32'h100, 8'h78); preload(32'h101, 8'h56);
        preload(32'h102, 8'h34); preload(32'h103, 8'h12);
        do_load(32'h100, MEM_W, 1'b0);
        n_checks++;
        if (Read_Value !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL lw_const: got %h expected 12345678", Read_Value);
        end
    endtask

    task automatic test_load_ext();
        preload(32'h200, 8'h80);
        do_load(32'h200, MEM_B, 1'b1);
        n_checks++;
        if (Read_Value !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL lb_signed: got %h expected ffffff80", Read_Value);
        end
        do_load(32'h200, MEM_B, 1'b0);
        n_checks++;
        if (Read_Value !== 32'h0000_0080) begin
            n_fail++;
            $display("FAIL lbu: got %h expected 00000080", Read_Value);
        end
        preload(32'h300, 8'h01); preload(32'h301, 8'h80);
        do_load(32'h300, MEM_H, 1'b1);
        n_checks++;
        if (Read_Value !== 32'hFFFF_8001) begin
            n_fail++;
            $display("FAIL lh_signed: got %h expected ffff8001", Read_Value);
        end
    endtask

    task automatic test_reset_mid_read();
        RN = 1'b1; Addr = 32'h100; Size = MEM_W; Signed = 1'b0;
        tick();
        RN = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (Mem_Success !== 1'b1 || mem_a !== 32'h0 || Read_Value !== 32'h0 || mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_read: success=%b a=%h rv=%h wr=%b expected 1 0 0 0",
                     Mem_Success, mem_a, Read_Value, mem_wr);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        do_load(32'h100, MEM_W, 1'b0);
    endtask

    task automatic test_store_half();
        preload(32'h42, 8'h5A);
        do_store(32'h40, MEM_H, 32'hAABB_CCDD, 1'b0);
        n_checks++;
        if (ram_rd(32'h40) !== 8'hDD || ram_rd(32'h41) !== 8'hCC || ram_rd(32'h42) !== 8'h5A) begin
            n_fail++;
            $display("FAIL sh_ram: got %h %h %h expected dd cc 5a",
                     ram_rd(32'h40), ram_rd(32'h41), ram_rd(32'h42));
        end
    endtask

    task automatic test_io_stall();
        io_buffer_full = 1'b1;
        WN = 1'b1; Addr = 32'h0003_0000; Size = MEM_B; Wvalue = 32'h1122_3377;
        tick();
        WN = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            clr = (c == 1);
            @(negedge clk);
            n_checks++;
            if (mem_wr !== 1'b0 || Mem_Success !== 1'b0 || mem_a !== 32'h0003_0000) begin
                n_fail++;
                $display("FAIL io_stall c=%0d: wr=%b success=%b a=%h expected 0 0 00030000",
                         c, mem_wr, Mem_Success, mem_a);
            end
        end
        tick();
        io_buffer_full = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_wr !== 1'b1 || mem_dout !== 8'h77 || mem_a !== 32'h0003_0000) begin
            n_fail++;
            $display("FAIL io_release: wr=%b d=%h a=%h expected 1 77 00030000", mem_wr, mem_dout, mem_a);
        end
        tick();
        @(negedge clk);
        ref_mem[32'h0003_0000] = 8'h77;
        n_checks++;
        if (Mem_Success !== 1'b1 || mem_wr !== 1'b0 || ram_rd(32'h0003_0000) !== 8'h77) begin
            n_fail++;
            $display("FAIL io_done: success=%b wr=%b ram=%h expected 1 0 77",
                     Mem_Success, mem_wr, ram_rd(32'h0003_0000));
        end
    endtask

    task automatic test_clr_read();
        logic [31:0] old;
        do_load(32'h100, MEM_W, 1'b0);
        old = model_load(32'h100, MEM_W, 1'b0);
        RN = 1'b1; Addr = 32'h200; Size = MEM_W; Signed = 1'b1;
        tick();
        RN = 1'b0;
        tick();
        tick();
        clr = 1'b1;
        @(negedge clk);
        n_checks++;
        if (Mem_Success !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_read_busy: success=%b expected 0", Mem_Success);
        end
        tick();
        clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (Mem_Success !== 1'b1 || Read_Value !== old) begin
            n_fail++;
            $display("FAIL clr_read_abort: success=%b rv=%h expected 1 %h", Mem_Success, Read_Value, old);
        end
        // RN together with clr in IDLE must not start a read.
        RN = 1'b1; clr = 1'b1; Addr = 32'h300; Size = MEM_H;
        tick();
        RN = 1'b0; clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (Mem_Success !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_blocks_rn: success=%b expected 1", Mem_Success);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (Mem_Success !== 1'b1 || Read_Value !== old) begin
            n_fail++;
            $display("FAIL clr_blocks_rn_hold: success=%b rv=%h expected 1 %h", Mem_Success, Read_Value, old);
        end
        clr = 1'b1;
        do_store(32'h520, MEM_B, 32'h0000_00E1, 1'b0);
        clr = 1'b0;
    endtask

    task automatic test_rn_wn_both();
        logic [31:0] old;
        old = Read_Value;
        preload(32'h501, 8'h99);
        do_store(32'h500, MEM_B, 32'h0000_003C, 1'b1);
        n_checks++;
        if (Read_Value !== old || ram_rd(32'h500) !== 8'h3C) begin
            n_fail++;
            $display("FAIL rn_wn_both: rv=%h ram=%h expected %h 3c", Read_Value, ram_rd(32'h500), old);
        end
    endtask

    task automatic test_rdy_freeze();
        WN = 1'b1; Addr = 32'h600; Size = MEM_H; Wvalue = 32'h0000_BEEF;
        tick();
        WN = 1'b0;
        rdy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h600) begin
            n_fail++;
            $display("FAIL rdy_freeze0: wr=%b a=%h expected 0 00000600", mem_wr, mem_a);
        end
        tick();
        rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h600 || mem_dout !== 8'hEF) begin
            n_fail++;
            $display("FAIL rdy_resume0: wr=%b a=%h d=%h expected 1 00000600 ef", mem_wr, mem_a, mem_dout);
        end
        tick();
        rdy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h601 || Mem_Success !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_freeze1: wr=%b a=%h success=%b expected 0 00000601 0",
                     mem_wr, mem_a, Mem_Success);
        end
        tick();
        rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h601 || mem_dout !== 8'hBE) begin
            n_fail++;
            $display("FAIL rdy_resume1: wr=%b a=%h d=%h expected 1 00000601 be", mem_wr, mem_a, mem_dout);
        end
        tick();
        @(negedge clk);
        ref_mem[32'h600] = 8'hEF;
        ref_mem[32'h601] = 8'hBE;
        n_checks++;
        if (Mem_Success !== 1'b1 || ram_rd(32'h600) !== 8'hEF || ram_rd(32'h601) !== 8'hBE) begin
            n_fail++;
            $display("FAIL rdy_done: success=%b ram=%h %h expected 1 ef be",
                     Mem_Success, ram_rd(32'h600), ram_rd(32'h601));
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  s;
        for (int i = 0; i < 260; i++) preload(32'h1000 + 32'(i), 8'($urandom));
        for (int i = 0; i < 4; i++) begin
            preload(32'hFFFF_FFFC + 32'(i), 8'($urandom));
            preload(32'(i), 8'($urandom));
        end
        for (int it = 0; it < 40; it++) begin
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else a = 32'h1000 + 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1)
                do_store(a, s, $urandom, 1'($urandom_range(0, 1)));
            else
                do_load(a, s, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_ext();
        test_reset_mid_read();
        test_store_half();
        test_io_stall();
        test_clr_read();
        test_rn_wn_both();
        test_rdy_freeze();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder end of the ROB-to-memory interface.
- Accepts one load or store at a time from the ROB (RN/WN, Addr, Wvalue, Size, Signed).
- Serialises the access into byte transfers on the single-port byte-wide RAM/IO bus.
- Returns load data on Read_Value, signalling idle/completion on Mem_Success.

Parameters:
- ADDR_W, 32, request and RAM address width.
- IO_BASE, 32'h30000, first address of the IO window; writes there honour io_buffer_full.
- IO_SPAN, 8, bytes in the IO window.

Ports:
- clk  in  1  system clock; only clock.
- rst  in  1  reset, asynchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- clr  in  1  pipeline flush from the ROB.
- RN  in  1  read request.
- WN  in  1  write request; WN wins if RN and WN are both high.
- Addr  in  32  byte address of the request.
- Wvalue  in  32  store data, low bytes used.
- Size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- Signed  in  1  sign-extend load result (LB/LH).
- Mem_Success  out  1  high only in IDLE: ready to accept; previous result valid.
- Read_Value  out  32  extended load result, held until the next accept.
- mem_din  in  8  RAM read byte, valid one cycle after mem_a.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  RAM write strobe (1 = write).
- io_buffer_full  in  1  UART buffer full.

Behaviour:
- Reset (async): state IDLE, Mem_Success=1, Read_Value=0, mem_a=0, mem_dout=0, mem_wr=0, byte counter=0, byte buffer=0. Reset mid-access aborts it; no partial completion is reported.
- rdy=0: all registers hold; mem_wr forced 0 during that cycle.
- N = 1/2/4 bytes from Size.
- States: IDLE, READ, WRITE.
- IDLE: Mem_Success=1, mem_wr=0.
  - At a clock edge with WN=1: latch Addr/Wvalue/N, go to WRITE.
  - Else with RN=1 and clr=0: latch Addr/N/Signed, go to READ.
  - Mem_Success drops the cycle after acceptance.
- READ, cycle k after accept (k=0..N): mem_a=Addr+k for k<N.
  - mem_din is captured into byte k-1 at the end of cycle k (k>=1).
  - After capturing byte N-1 (end of cycle N): Read_Value = bytes zero- or sign-extended from bit 8N-1; go to IDLE.
  - Mem_Success=1 in cycle N+1.
  - LW busy 5 cycles; LB busy 2.
- WRITE, cycle k: mem_a=Addr+k, mem_dout=Wvalue[8k+7:8k], mem_wr=1.
  - After byte N-1, go to IDLE; Mem_Success=1 in cycle N.
  - If mem_a is in [IO_BASE, IO_BASE+IO_SPAN) and io_buffer_full=1, mem_wr=0 and k holds until io_buffer_full=0.
- clr=1 during READ: abort at that edge, go to IDLE, Read_Value unchanged.
- clr=1 during WRITE: ignored; the committed store completes.
- clr=1 in IDLE: a simultaneous RN is not accepted; WN still is.
- Address wrap: Addr+k is computed modulo 2^ADDR_W.
- No misalignment check; bytes are issued at Addr..Addr+N-1 as given.
- Requests arriving while not IDLE are ignored; the requester must hold or re-present them.

Decomposition:
- Shared constants file: Size codes (MEM_B/MEM_H/MEM_W), state encodings, IO_BASE.
- One natural sub-module, mem_load_ext: combinational byte-assembly plus sign/zero extension (bytes, N, Signed -> 32-bit).
- Everything else lives in mem_ctrl.

Test Plan:
- Reset then idle: Mem_Success=1, mem_wr=0, Read_Value=0. Assert rst mid-READ -> immediate IDLE, Mem_Success=1.
- RAM[0x100..0x103]=78 56 34 12, RN, Size=10, Addr=0x100 -> mem_a 0x100..0x103 on cycles 0..3. Mem_Success=1 in cycle 5, Read_Value=0x12345678.
- RAM[0x200]=0x80, LB Signed=1 -> 0xFFFFFF80. Signed=0 -> 0x00000080. LH of 0x8001 Signed=1 -> 0xFFFF8001.
- WN, Size=01, Addr=0x40, Wvalue=0xAABBCCDD -> mem_wr=1 with bytes DD at 0x40, CC at 0x41. Mem_Success=1 in cycle 2; RAM[0x42] untouched.
- Write SB to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then one mem_wr pulse with the byte. clr during the stall -> write still completes.
- LW in flight, clr at cycle 2 -> IDLE next cycle, Read_Value keeps its old value. RN and WN both high in IDLE -> write performed.
